// File: rtl/dl_write_scheduler.sv
// dl_write_scheduler: bit/phase sequencer plus a single-entry write buffer
// that serialises one word into delay line DL44 or DL31 during its slot phase.
// Requester A has priority over requester B.
// Optional feature: define DL_WRITE_SCHEDULER_PARITY_EN to extend each window
// by one bit that carries the odd parity of the buffered word.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | buffer empty, requests may be accepted
// S_WAIT  | buffer full, accepted mid-window of its own slot; skip it
// S_ARMED | buffer full, write runs whenever phase == slot
module dl_write_scheduler #(
    parameter int WORD_BITS = 26
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 BT,
    input  logic                 A_REQ,
    input  logic                 A_LINE,
    input  logic [1:0]           A_SLOT,
    input  logic [WORD_BITS-1:0] A_DATA,
    output logic                 A_ACK,
    output logic                 A_DONE,
    input  logic                 B_REQ,
    input  logic                 B_LINE,
    input  logic [1:0]           B_SLOT,
    input  logic [WORD_BITS-1:0] B_DATA,
    output logic                 B_ACK,
    output logic                 B_DONE,
    output logic                 PHW,
    output logic                 PHX,
    output logic                 PHY,
    output logic                 PHZ,
    output logic [4:0]           BITN,
    output logic                 DL44,
    output logic                 DL31,
    output logic                 DLD,
    output logic                 BUSY
);

`ifdef DL_WRITE_SCHEDULER_PARITY_EN
    localparam int WIN = WORD_BITS + 1;
`else
    localparam int WIN = WORD_BITS;
`endif
    localparam logic [4:0] LAST_BIT = 5'(WIN - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ARMED} state_t;

    state_t                 state, state_nxt;
    logic [1:0]             phase, phase_nxt;
    logic [4:0]             bitn, bitn_nxt;
    logic                   buf_line, buf_owner;
    logic [1:0]             buf_slot;
    logic [WORD_BITS-1:0]   buf_data;
    logic                   load, load_b;
    logic [1:0]             load_slot;
    logic                   ack_a_nxt, ack_b_nxt, done_nxt;
    logic                   active, dld_bit;

    // Position the sequencer will hold after this edge (used to decide on arming).
    always_comb begin
        phase_nxt = phase;
        bitn_nxt  = bitn;
        if (BT) begin
            if (bitn == LAST_BIT) begin
                bitn_nxt  = '0;
                phase_nxt = phase + 2'd1;
            end else begin
                bitn_nxt  = bitn + 5'd1;
            end
        end
    end

    // Bit/phase sequencer registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            phase <= 2'd0;
            bitn  <= '0;
        end else begin
            phase <= phase_nxt;
            bitn  <= bitn_nxt;
        end
    end

    assign active = (state == S_ARMED) && (phase == buf_slot);

    // Buffer FSM next-state, accept and completion decisions.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_b    = !A_REQ;
        load_slot = A_REQ ? A_SLOT : B_SLOT;
        ack_a_nxt = 1'b0;
        ack_b_nxt = 1'b0;
        done_nxt  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (A_REQ || B_REQ) begin
                    load      = 1'b1;
                    ack_a_nxt = A_REQ;
                    ack_b_nxt = !A_REQ;
                    // Landing inside our own window past bit 0 means a full rotation wait.
                    state_nxt = (phase_nxt == load_slot && bitn_nxt != '0) ? S_WAIT : S_ARMED;
                end
            end
            S_WAIT: begin
                if (!(phase_nxt == buf_slot && bitn_nxt != '0))
                    state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (active && BT && bitn == LAST_BIT) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM state and handshake pulse registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= S_IDLE;
            A_ACK  <= 1'b0;
            B_ACK  <= 1'b0;
            A_DONE <= 1'b0;
            B_DONE <= 1'b0;
        end else begin
            state  <= state_nxt;
            A_ACK  <= ack_a_nxt;
            B_ACK  <= ack_b_nxt;
            A_DONE <= done_nxt && !buf_owner;
            B_DONE <= done_nxt && buf_owner;
        end
    end

    // Write buffer capture; the requester's fields are irrelevant after ACK.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            buf_line  <= 1'b0;
            buf_owner <= 1'b0;
            buf_slot  <= 2'd0;
            buf_data  <= '0;
        end else if (load) begin
            buf_line  <= A_REQ ? A_LINE : B_LINE;
            buf_owner <= load_b;
            buf_slot  <= load_slot;
            buf_data  <= A_REQ ? A_DATA : B_DATA;
        end
    end

    // Serial bit select, LSB first; the optional extra bit is odd parity.
    always_comb begin
        dld_bit = 1'b0;
`ifdef DL_WRITE_SCHEDULER_PARITY_EN
        if (bitn == 5'(WORD_BITS))
            dld_bit = ~(^buf_data);
        else
            dld_bit = buf_data[bitn];
`else
        dld_bit = buf_data[bitn];
`endif
    end

    assign PHW  = (phase == 2'd0);
    assign PHX  = (phase == 2'd1);
    assign PHY  = (phase == 2'd2);
    assign PHZ  = (phase == 2'd3);
    assign BITN = bitn;
    assign DL44 = active && !buf_line;
    assign DL31 = active && buf_line;
    assign DLD  = active && dld_bit;
    assign BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_dl_write_scheduler.sv
// tb_dl_write_scheduler: scoreboard bench for dl_write_scheduler.
// The reference model counts bit-times since reset and derives phase, bit
// index and write windows from that count arithmetically.
module tb_dl_write_scheduler;
    localparam int WB = 26;
`ifdef DL_WRITE_SCHEDULER_PARITY_EN
    localparam int WIN = WB + 1;
`else
    localparam int WIN = WB;
`endif
    localparam int ROT = 4 * WIN;
    localparam int LIMIT = 4000;

    logic CLK, RESET, BT;
    logic A_REQ, A_LINE, B_REQ, B_LINE;
    logic [1:0] A_SLOT, B_SLOT;
    logic [WB-1:0] A_DATA, B_DATA;
    logic A_ACK, A_DONE, B_ACK, B_DONE;
    logic PHW, PHX, PHY, PHZ, DL44, DL31, DLD, BUSY;
    logic [4:0] BITN;

    dl_write_scheduler #(.WORD_BITS(WB)) dut (
        .CLK(CLK), .RESET(RESET), .BT(BT),
        .A_REQ(A_REQ), .A_LINE(A_LINE), .A_SLOT(A_SLOT), .A_DATA(A_DATA),
        .A_ACK(A_ACK), .A_DONE(A_DONE),
        .B_REQ(B_REQ), .B_LINE(B_LINE), .B_SLOT(B_SLOT), .B_DATA(B_DATA),
        .B_ACK(B_ACK), .B_DONE(B_DONE),
        .PHW(PHW), .PHX(PHX), .PHY(PHY), .PHZ(PHZ), .BITN(BITN),
        .DL44(DL44), .DL31(DL31), .DLD(DLD), .BUSY(BUSY)
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;
    bit bt_rand = 0;

    // reference model state
    longint t = 0;
    bit m_busy = 0, m_owner = 0, m_line = 0;
    logic [WB-1:0] m_data = '0;
    longint m_start = 0, m_end = 0;
    bit ackq[$];
    bit doneq[$];

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached (checks=%0d errors=%0d)", checks, errors);
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0d", name, act, exp, t);
        end
    endtask

    function automatic bit exp_bit(input logic [WB-1:0] d, input int k);
        if (k < WB) return d[k];
        return ~(^d);
    endfunction

    // bit-time strobe source
    initial begin
        BT = 1'b1;
        forever begin
            @(negedge CLK);
            BT = bt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // reference model: advances at each rising edge using the sampled inputs
    always @(posedge CLK) begin
        longint tn, s;
        if (RESET) begin
            t = 0;
            m_busy = 0;
            ackq.delete();
            doneq.delete();
        end else begin
            tn = t + (BT ? 1 : 0);
            if (m_busy) begin
                if (tn == m_end) begin
                    m_busy = 0;
                    doneq.push_back(m_owner);
                end
            end else if (A_REQ || B_REQ) begin
                m_owner = !A_REQ;
                m_line  = A_REQ ? A_LINE : B_LINE;
                m_data  = A_REQ ? A_DATA : B_DATA;
                s = tn - (tn % ROT) + (A_REQ ? A_SLOT : B_SLOT) * WIN;
                if (s < tn) s += ROT;
                m_start = s;
                m_end   = s + WIN;
                m_busy  = 1;
                ackq.push_back(m_owner);
            end
            t = tn;
        end
    end

    // monitor: compares DUT outputs against the model on the falling edge
    always @(negedge CLK) begin
        bit g, o;
        logic [3:0] ph;
        if (mon_en) begin
            g  = m_busy && t >= m_start && t < m_end;
            ph = 4'b1000 >> ((t / WIN) % 4);
            check("bitn", BITN, t % WIN);
            check("phase", {PHW, PHX, PHY, PHZ}, ph);
            check("busy", BUSY, m_busy);
            check("dl44", DL44, g && !m_line);
            check("dl31", DL31, g && m_line);
            check("dld", DLD, g ? exp_bit(m_data, int'(t - m_start)) : 1'b0);
            if (ackq.size() > 0) begin
                o = ackq.pop_front();
                check("ack_pair", {A_ACK, B_ACK}, o ? 2'b01 : 2'b10);
            end else begin
                check("ack_idle", {A_ACK, B_ACK}, 2'b00);
            end
            if (doneq.size() > 0) begin
                o = doneq.pop_front();
                check("done_pair", {A_DONE, B_DONE}, o ? 2'b01 : 2'b10);
            end else begin
                check("done_idle", {A_DONE, B_DONE}, 2'b00);
            end
        end
    end

    task automatic do_req(input bit who, input bit line, input logic [1:0] slot, input logic [WB-1:0] data);
        int n = 0;
        if (!who) begin
            A_LINE = line; A_SLOT = slot; A_DATA = data; A_REQ = 1'b1;
        end else begin
            B_LINE = line; B_SLOT = slot; B_DATA = data; B_REQ = 1'b1;
        end
        do begin
            @(negedge CLK);
            n++;
        end while (!(who ? B_ACK : A_ACK) && n < LIMIT);
        check(who ? "ack_b_timeout" : "ack_a_timeout", n >= LIMIT, 0);
        if (!who) A_REQ = 1'b0;
        else B_REQ = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while ((BUSY || A_DONE || B_DONE) && n < LIMIT);
        check("idle_timeout", n >= LIMIT, 0);
    endtask

    initial begin
        int n;
        RESET = 1'b1;
        A_REQ = 0; A_LINE = 0; A_SLOT = 0; A_DATA = '0;
        B_REQ = 0; B_LINE = 0; B_SLOT = 0; B_DATA = '0;
        @(negedge CLK);
        @(negedge CLK);
        mon_en = 1;
        check("rst_phw", PHW, 1);
        check("rst_bitn", BITN, 0);
        check("rst_busy", BUSY, 0);
        check("rst_out", {A_ACK, A_DONE, B_ACK, B_DONE, DL44, DL31, DLD}, 0);
        RESET = 1'b0;

        // one full rotation with a strobe every cycle
        for (int p = 1; p <= 4; p++) begin
            repeat (WIN) @(negedge CLK);
            check("rot_phase", {PHW, PHX, PHY, PHZ}, 4'b1000 >> (p % 4));
        end
        check("rot_bitn", BITN, 0);

        // single write to DL44 slot Y with alternating data
        do_req(0, 0, 2'd2, 26'h2AAAAAA);
        wait_idle();

        // simultaneous requests: A first, then B
        fork
            do_req(0, 1, 2'd0, 26'h1234567);
            do_req(1, 0, 2'd3, 26'h0F0F0F0);
        join
        wait_idle();

        // accepted at X bit 5 of slot X: waits almost a full rotation
        n = 0;
        while ((t % ROT) != WIN + 4 && n < LIMIT) begin
            @(negedge CLK);
            n++;
        end
        do_req(0, 1, 2'd1, 26'h3FFFFFF);
        n = 0;
        while (!(DL44 || DL31) && n < 400) begin
            @(negedge CLK);
            n++;
        end
        check("late_start", n, ROT - 5);
        wait_idle();

        // reset mid-write on DL31
        do_req(1, 1, 2'd3, 26'h15A5A5A);
        n = 0;
        while (!(DL31 && BITN == 5'd10) && n < LIMIT) begin
            @(negedge CLK);
            n++;
        end
        check("abort_reach", n >= LIMIT, 0);
        RESET = 1'b1;
        @(negedge CLK);
        check("abort_dl31", DL31, 0);
        check("abort_busy", BUSY, 0);
        check("abort_phw", PHW, 1);
        check("abort_bdone", B_DONE, 0);
        RESET = 1'b0;
        repeat (ROT + 10) @(negedge CLK);

`ifdef DL_WRITE_SCHEDULER_PARITY_EN
        do_req(0, 0, 2'd0, 26'h0000001);
        wait_idle();
        do_req(0, 1, 2'd1, 26'h0000000);
        wait_idle();
`endif

        // randomized traffic with irregular strobes
        bt_rand = 1;
        fork
            for (int i = 0; i < 6; i++) begin
                repeat ($urandom_range(0, 40)) @(negedge CLK);
                do_req(0, 1'($urandom), 2'($urandom), WB'($urandom));
            end
            for (int j = 0; j < 6; j++) begin
                repeat ($urandom_range(0, 40)) @(negedge CLK);
                do_req(1, 1'($urandom), 2'($urandom), WB'($urandom));
            end
        join
        wait_idle();
        repeat (3) @(negedge CLK);

        check("ackq_empty", ackq.size(), 0);
        check("doneq_empty", doneq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dl_write_scheduler.md
DL_WRITE_SCHEDULER -- requirements
Module: dl_write_scheduler

Interface
REQ-001 SHALL have parameter WORD_BITS, default 26: bit-times per phase window (word length).
REQ-002 SHALL have port CLK, input, 1: single system clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port BT, input, 1: bit-time strobe; the sequencer advances one bit per CLK edge with BT high.
REQ-005 SHALL have ports A_REQ (in, 1), A_LINE (in, 1; 0=DL44, 1=DL31), A_SLOT (in, 2; 0..3 = W,X,Y,Z), A_DATA (in, WORD_BITS): requester A, high priority.
REQ-006 SHALL have ports A_ACK (out, 1; accept pulse) and A_DONE (out, 1; write-complete pulse).
REQ-007 SHALL have ports B_REQ, B_LINE, B_SLOT, B_DATA, B_ACK, B_DONE, identical to A: requester B, low priority.
REQ-008 SHALL have ports PHW, PHX, PHY, PHZ, output, 1 each: one-hot current phase.
REQ-009 SHALL have port BITN, output, 5: current bit index within the phase window.
REQ-010 SHALL have ports DL44 and DL31, output, 1 each: delay-line write gates.
REQ-011 SHALL have port DLD, output, 1: serial write data; BUSY, output, 1: write buffer occupied.

Function
REQ-012 SHALL, on each CLK with BT=1, increment BITN; at BITN=last bit, wrap to 0 and advance phase W->X->Y->Z->W.
REQ-013 SHALL hold BITN and phase unchanged on cycles with BT=0.
REQ-014 SHALL hold one write buffer (line, slot, data, owner); BUSY=1 while it is occupied.
REQ-015 SHALL, with the buffer empty, latch a request and pulse the owner's ACK for exactly one cycle, on the cycle after REQ is sampled high.
REQ-016 SHALL grant A when A_REQ and B_REQ are high on the same cycle; B keeps waiting, with no ACK until the buffer empties again.
REQ-017 SHALL accept no request while BUSY=1, or in the cycle in which the buffer empties; there is no same-cycle bypass.
REQ-018 SHALL leave the requester responsible for holding REQ and its fields stable until ACK; once ACK is given, the buffered copy is used.
REQ-019 SHALL start the write on the first BT strobe at which phase==slot and BITN==0; a request for the current phase accepted mid-window waits one full rotation (4*WORD_BITS bit-times).
REQ-020 SHALL, during the write window, assert the selected gate (DL44 or DL31, never both) for WORD_BITS bit-times and drive DLD with data LSB first, bit k at BITN=k.
REQ-021 SHALL deassert the gate, pulse the owner's DONE for one cycle, and empty the buffer on the CLK following the last bit's BT strobe.
REQ-022 SHALL drive DLD=0 whenever no gate is asserted.

Reset
REQ-023 SHALL, with RESET high at a CLK edge, set phase=W (PHW=1, others 0), BITN=0, buffer empty, BUSY=0, and ACK/DONE/DL44/DL31/DLD=0.
REQ-024 SHALL, on RESET mid-write, abort the write: the gate drops on that edge, no DONE is issued, and the data is discarded.
REQ-025 SHALL give RESET priority over BT and REQ on the same cycle.

Configuration
REQ-026 SHALL, with macro DL_WRITE_SCHEDULER_PARITY_EN defined, make the window WORD_BITS+1 bit-times, with the final bit on DLD the odd parity of the buffered word and the gate held for that bit.
REQ-027 SHALL, without DL_WRITE_SCHEDULER_PARITY_EN, use windows of exactly WORD_BITS bit-times and generate no parity logic.

Verification
REQ-028 SHALL cover: BT=1 every cycle, 104 cycles after reset -> phase W,X,Y,Z each 26 cycles, back at W with BITN=0.
REQ-029 SHALL cover: A_REQ with LINE=0, SLOT=2 (Y), DATA=0x2AAAAAA, at phase W -> A_ACK one cycle later; DL44 high BITN 0..25 of Y; DLD alternates 0,1,...; A_DONE follows.
REQ-030 SHALL cover: A_REQ and B_REQ together -> A_ACK only; B_ACK on the cycle after A_DONE+1; B's write completes in its slot.
REQ-031 SHALL cover: request for SLOT=1 accepted at phase X, BITN=5 -> write starts 99 bit-times later at the next X, BITN=0.
REQ-032 SHALL cover: RESET at BITN=10 of a DL31 write -> DL31=0 next edge, no B_DONE, BUSY=0, PHW=1.
REQ-033 SHALL cover: with PARITY_EN, DATA=0x0000001 -> 27-bit window, parity bit 0; DATA=0 -> parity bit 1.
